// File: rtl/bullet_launcher.sv
// One bullet slot: accepts a launch request, steps the bullet once per frame,
// retires it on screen exit or hit, then waits out a cooldown before re-arming.
module bullet_launcher #(
    parameter int          SCREEN_W        = 640,
    parameter int          SCREEN_H        = 480,
    parameter int          RADIUS          = 4,
    parameter int          SPEED           = 8,
    parameter logic [15:0] COLOR           = 16'hFFE0,
    parameter int          COOLDOWN_FRAMES = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        fire,
    input  logic [10:0] fire_x,
    input  logic [10:0] fire_y,
    input  logic [1:0]  fire_dir,
    input  logic        hit,
    output logic        fire_ack,
    output logic        active,
    output logic        ready,
    output logic [10:0] BulletX,
    output logic [10:0] BulletY,
    output logic [10:0] BulletRadius,
    output logic [15:0] BulletColor
);

    localparam int                 CNT_W   = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CNT_W-1:0]   CD_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]   CD_ONE  = CNT_W'(1);
    localparam logic [10:0]        X_LIM   = 11'(SCREEN_W);
    localparam logic [10:0]        Y_LIM   = 11'(SCREEN_H);
    localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - 1);
    localparam logic signed [11:0] STEP    = 12'(SPEED);
    localparam logic [10:0]        RAD     = 11'(RADIUS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_frame_sync;
    logic              r_tick;
    logic [10:0]       r_x;
    logic [10:0]       r_y;
    logic [1:0]        r_dir;
    logic [CNT_W-1:0]  r_cd_cnt;
    logic              r_fire_ack;
    logic              r_active;
    logic              r_ready;
    logic [10:0]       r_radius;

    logic              w_vertical;
    logic signed [11:0] w_cur;
    logic signed [11:0] w_next;
    logic              w_exit;
    logic              w_retire;
    logic              w_fire_ok;

    // Bits [1:0] synchronise frame_clk; bit [2] is the previous sample for edge detect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_sync <= 3'b000;
            r_tick       <= 1'b0;
        end else begin
            r_frame_sync <= {r_frame_sync[1:0], frame_clk};
            r_tick       <= r_frame_sync[1] & ~r_frame_sync[2];
        end
    end

    always_comb begin
        w_vertical = ~r_dir[1];
        w_cur      = w_vertical ? $signed({1'b0, r_y}) : $signed({1'b0, r_x});
        w_next     = r_dir[0] ? (w_cur + STEP) : (w_cur - STEP);
        w_exit     = (w_next < 12'sd0) || (w_next > (w_vertical ? Y_MAX : X_MAX));
        w_retire   = (r_state == ST_FLYING) && (hit || (r_tick && w_exit));
        w_fire_ok  = fire && (fire_x < X_LIM) && (fire_y < Y_LIM);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_x        <= 11'd0;
            r_y        <= 11'd0;
            r_dir      <= 2'b00;
            r_cd_cnt   <= '0;
            r_fire_ack <= 1'b0;
            r_active   <= 1'b0;
            r_ready    <= 1'b1;
            r_radius   <= 11'd0;
        end else begin
            r_fire_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire_ok) begin
                        r_x        <= fire_x;
                        r_y        <= fire_y;
                        r_dir      <= fire_dir;
                        r_fire_ack <= 1'b1;
                        r_active   <= 1'b1;
                        r_ready    <= 1'b0;
                        r_radius   <= RAD;
                        r_state    <= ST_FLYING;
                    end
                end
                ST_FLYING: begin
                    // Hit wins over a coincident tick; on exit the last legal position is kept.
                    if (w_retire) begin
                        r_active <= 1'b0;
                        r_radius <= 11'd0;
                        if (COOLDOWN_FRAMES == 0) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state  <= ST_COOLDOWN;
                            r_cd_cnt <= CD_LOAD;
                        end
                    end else if (r_tick) begin
                        if (w_vertical) begin
                            r_y <= w_next[10:0];
                        end else begin
                            r_x <= w_next[10:0];
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (r_tick) begin
                        if (r_cd_cnt == CD_ONE) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_cd_cnt <= r_cd_cnt - CD_ONE;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                    r_radius <= 11'd0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign fire_ack     = r_fire_ack;
    assign active       = r_active;
    assign ready        = r_ready;
    assign BulletX      = r_x;
    assign BulletY      = r_y;
    assign BulletRadius = r_radius;
    assign BulletColor  = COLOR;

endmodule
